// File: rtl/update_global_lvl_states_pkg.sv
// Bin-manager constants shared by the global level-states writer and its neighbours.
// Holds bus widths, the {bin_id, has_bkt} field order and the writer FSM encoding.
// No logic of its own.
package update_global_lvl_states_pkg;

    localparam int WIDTH_LVL              = 16;
    localparam int WIDTH_BIN_ID           = 10;
    localparam int ADDR_WIDTH_LVLS_STATES = 9;
    localparam int WIDTH_LVL_STATES       = WIDTH_BIN_ID + 1;

    // One BRAM entry: owning bin in the upper bits, has_bkt flag in bit 0.
    typedef struct packed {
        logic [WIDTH_BIN_ID-1:0] bin_id;
        logic                    has_bkt;
    } lvl_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PUSH  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } upd_state_t;

    function automatic logic [WIDTH_LVL_STATES-1:0] pack_lvl_state(
        input logic [WIDTH_BIN_ID-1:0] bin_id,
        input logic                    has_bkt
    );
        lvl_state_t s;
        s.bin_id  = bin_id;
        s.has_bkt = has_bkt;
        return s;
    endfunction

endpackage

// File: rtl/update_global_lvl_states.sv
// Writer for the global level-states BRAM: records level ownership on push, clears levels above a backtrack level.
// Latency: push done 2 cycles after start; clear done N+1 cycles after start (N = levels cleared).
// Backpressure: none; starts are sampled only when idle and dropped while busy_o is high (clear beats push).
//
// Ports: clk/rst (async active-low); start_push/lvl_i/bin_id_i; start_clear/bkt_lvl_i;
//        busy_o, done_update, max_lvl_o; apply_update_o + ram_* write port toward the parent's BRAM mux.
module update_global_lvl_states #(
    parameter int WIDTH_LVL              = update_global_lvl_states_pkg::WIDTH_LVL,
    parameter int WIDTH_BIN_ID           = update_global_lvl_states_pkg::WIDTH_BIN_ID,
    parameter int WIDTH_LVL_STATES       = update_global_lvl_states_pkg::WIDTH_LVL_STATES,
    parameter int ADDR_WIDTH_LVLS_STATES = update_global_lvl_states_pkg::ADDR_WIDTH_LVLS_STATES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_push,
    input  logic [WIDTH_LVL-1:0]              lvl_i,
    input  logic [WIDTH_BIN_ID-1:0]           bin_id_i,
    input  logic                              start_clear,
    input  logic [WIDTH_LVL-1:0]              bkt_lvl_i,
    output logic                              busy_o,
    output logic                              done_update,
    output logic [WIDTH_LVL-1:0]              max_lvl_o,
    output logic                              apply_update_o,
    output logic                              ram_we_l_state_o,
    output logic [WIDTH_LVL_STATES-1:0]       ram_data_l_state_o,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_l_state_o
);

    import update_global_lvl_states_pkg::upd_state_t;
    import update_global_lvl_states_pkg::ST_IDLE;
    import update_global_lvl_states_pkg::ST_PUSH;
    import update_global_lvl_states_pkg::ST_CLEAR;
    import update_global_lvl_states_pkg::ST_DONE;
    import update_global_lvl_states_pkg::pack_lvl_state;

    upd_state_t                        state_q, state_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              we_q, we_d;
    logic                              apply_q, apply_d;
    logic [WIDTH_LVL_STATES-1:0]       data_q, data_d;
    logic [ADDR_WIDTH_LVLS_STATES-1:0] addr_q, addr_d;
    logic [WIDTH_LVL-1:0]              max_q, max_d;
    // Level whose clear write is on the port this cycle.
    logic [WIDTH_LVL-1:0]              lvl_cur_q, lvl_cur_d;
    logic [WIDTH_LVL-1:0]              bkt_q, bkt_d;
    logic [WIDTH_LVL-1:0]              last_lvl;

    // Lowest level a clear may touch; level bkt itself (and so level 0) survives.
    assign last_lvl = bkt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        we_d      = 1'b0;
        data_d    = '0;
        addr_d    = '0;
        max_d     = max_q;
        lvl_cur_d = lvl_cur_q;
        bkt_d     = bkt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_clear) begin
                    bkt_d = bkt_lvl_i;
                    if (max_q > bkt_lvl_i) begin
                        // First clear write goes out next cycle, at the current maximum.
                        we_d      = 1'b1;
                        addr_d    = max_q[ADDR_WIDTH_LVLS_STATES-1:0];
                        lvl_cur_d = max_q;
                        state_d   = ST_CLEAR;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (start_push) begin
                    we_d    = 1'b1;
                    addr_d  = lvl_i[ADDR_WIDTH_LVLS_STATES-1:0];
                    data_d  = pack_lvl_state(bin_id_i, 1'b0);
                    max_d   = lvl_i;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_CLEAR: begin
                if (lvl_cur_q == last_lvl) begin
                    done_d  = 1'b1;
                    max_d   = bkt_q;
                    state_d = ST_DONE;
                end else begin
                    lvl_cur_d = lvl_cur_q - 1'b1;
                    we_d      = 1'b1;
                    addr_d    = lvl_cur_d[ADDR_WIDTH_LVLS_STATES-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        apply_d = we_d;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            apply_q   <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            max_q     <= '0;
            lvl_cur_q <= '0;
            bkt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_q      <= we_d;
            apply_q   <= apply_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            max_q     <= max_d;
            lvl_cur_q <= lvl_cur_d;
            bkt_q     <= bkt_d;
        end
    end

    assign busy_o             = busy_q;
    assign done_update        = done_q;
    assign max_lvl_o          = max_q;
    assign apply_update_o     = apply_q;
    assign ram_we_l_state_o   = we_q;
    assign ram_data_l_state_o = data_q;
    assign ram_addr_l_state_o = addr_q;

endmodule

// File: tb/tb_update_global_lvl_states.sv
module tb_update_global_lvl_states;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_push;
    logic [15:0] lvl_i;
    logic [9:0]  bin_id_i;
    logic        start_clear;
    logic [15:0] bkt_lvl_i;
    logic        busy_o;
    logic        done_update;
    logic [15:0] max_lvl_o;
    logic        apply_update_o;
    logic        ram_we_l_state_o;
    logic [10:0] ram_data_l_state_o;
    logic [8:0]  ram_addr_l_state_o;

    int checks   = 0;
    int failures = 0;

    // Reference state: highest recorded level and expected BRAM image.
    logic [15:0] mdl_max;
    logic [10:0] mdl_mem [512];
    logic [10:0] dut_mem [512];

    always #5 clk = ~clk;

    update_global_lvl_states dut (
        .clk                (clk),
        .rst                (rst),
        .start_push         (start_push),
        .lvl_i              (lvl_i),
        .bin_id_i           (bin_id_i),
        .start_clear        (start_clear),
        .bkt_lvl_i          (bkt_lvl_i),
        .busy_o             (busy_o),
        .done_update        (done_update),
        .max_lvl_o          (max_lvl_o),
        .apply_update_o     (apply_update_o),
        .ram_we_l_state_o   (ram_we_l_state_o),
        .ram_data_l_state_o (ram_data_l_state_o),
        .ram_addr_l_state_o (ram_addr_l_state_o)
    );

    // Issue one operation and follow it to completion. inject_at > 0 raises
    // start_push for one cycle at that point of the operation (must be ignored).
    task automatic run_op(input bit do_push, input bit do_clr, input int lvl,
                          input int bin, input int bkt, input int inject_at, input string tag);
        logic [8:0]  exp_addr[$];
        logic [10:0] exp_data[$];
        logic [15:0] new_max;
        int nw, cyc, got_w;
        bit seen_done;
        int bad_port;

        new_max = mdl_max;
        if (do_clr) begin
            if (int'(mdl_max) > bkt) begin
                for (int l = int'(mdl_max); l > bkt; l--) begin
                    exp_addr.push_back(9'(l % 512));
                    exp_data.push_back(11'd0);
                end
                new_max = 16'(bkt);
            end
        end else begin
            exp_addr.push_back(9'(lvl % 512));
            exp_data.push_back(11'(bin * 2));
            new_max = 16'(lvl);
        end
        nw = exp_addr.size();

        @(negedge clk);
        start_push  = do_push;
        start_clear = do_clr;
        lvl_i       = 16'(lvl);
        bin_id_i    = 10'(bin);
        bkt_lvl_i   = 16'(bkt);
        @(negedge clk);
        start_push  = 1'b0;
        start_clear = 1'b0;
        lvl_i       = 16'($urandom);
        bin_id_i    = 10'($urandom);
        bkt_lvl_i   = 16'($urandom);

        cyc = 1; got_w = 0; seen_done = 0; bad_port = 0;
        while (cyc < 1100) begin
            start_push = (cyc == inject_at);
            if (ram_we_l_state_o === 1'b1) begin
                if (got_w < nw) begin
                    if (ram_addr_l_state_o !== exp_addr[got_w] || ram_data_l_state_o !== exp_data[got_w])
                        bad_port++;
                end
                dut_mem[ram_addr_l_state_o] = ram_data_l_state_o;
                got_w++;
            end else if (ram_addr_l_state_o !== 9'd0 || ram_data_l_state_o !== 11'd0) begin
                bad_port++;
            end
            if (apply_update_o !== ram_we_l_state_o) bad_port++;
            if (busy_o !== 1'b1) bad_port++;
            if (done_update === 1'b1) begin
                seen_done = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end

        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL %s done_timeout: got no done_update after %0d cycles, required done at cycle %0d", tag, cyc, nw + 1);
        end
        checks++;
        if (cyc != nw + 1) begin
            failures++;
            $display("FAIL %s latency: done at cycle %0d, required %0d", tag, cyc, nw + 1);
        end
        checks++;
        if (got_w != nw) begin
            failures++;
            $display("FAIL %s write_count: got %0d, required %0d", tag, got_w, nw);
        end
        checks++;
        if (bad_port != 0) begin
            failures++;
            $display("FAIL %s port_values: %0d bad cycles (addr/data/apply/busy), required 0", tag, bad_port);
        end

        if (do_clr) begin
            for (int i = 0; i < nw; i++) mdl_mem[exp_addr[i]] = 11'd0;
        end else begin
            mdl_mem[exp_addr[0]] = exp_data[0];
        end
        mdl_max = new_max;

        checks++;
        if (max_lvl_o !== mdl_max) begin
            failures++;
            $display("FAIL %s max_lvl: got %0d, required %0d", tag, max_lvl_o, mdl_max);
        end

        @(negedge clk);
        start_push = 1'b0;
        checks++;
        if (done_update !== 1'b0 || busy_o !== 1'b0 || ram_we_l_state_o !== 1'b0) begin
            failures++;
            $display("FAIL %s post_done: done=%b busy=%b we=%b, required 0 0 0", tag, done_update, busy_o, ram_we_l_state_o);
        end
        @(negedge clk);
        checks++;
        if (ram_we_l_state_o !== 1'b0 || max_lvl_o !== mdl_max) begin
            failures++;
            $display("FAIL %s idle_quiet: we=%b max=%0d, required we=0 max=%0d", tag, ram_we_l_state_o, max_lvl_o, mdl_max);
        end
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 512; i++) if (dut_mem[i] !== mdl_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s mem_image: %0d differing entries, required 0", tag, bad);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start_push = 0; start_clear = 0; lvl_i = 0; bin_id_i = 0; bkt_lvl_i = 0;
        mdl_max = 0;
        for (int i = 0; i < 512; i++) begin mdl_mem[i] = 11'd0; dut_mem[i] = 11'd0; end
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 0 || done_update !== 0 || max_lvl_o !== 0 || apply_update_o !== 0 ||
            ram_we_l_state_o !== 0 || ram_data_l_state_o !== 0 || ram_addr_l_state_o !== 0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b max=%0d apply=%b we=%b data=%0d addr=%0d, required all 0",
                     busy_o, done_update, max_lvl_o, apply_update_o, ram_we_l_state_o, ram_data_l_state_o, ram_addr_l_state_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_push;
        run_op(1, 0, 3, 5, 0, 0, "push_3_5");
        check_mem("push_3_5");
    endtask

    task automatic test_push_sequence;
        for (int i = 1; i <= 4; i++) run_op(1, 0, i, 6 + i, 0, 0, "push_seq");
        check_mem("push_seq");
    endtask

    task automatic test_clear;
        run_op(0, 1, 0, 0, 1, 0, "clear_bkt1");
        check_mem("clear_bkt1");
        checks++;
        if (dut_mem[1] !== 11'(7 * 2)) begin
            failures++;
            $display("FAIL clear_bkt1 entry1: got %0d, required %0d", dut_mem[1], 7 * 2);
        end
    endtask

    task automatic test_noop_clear;
        for (int i = 2; i <= 4; i++) run_op(1, 0, i, 20 + i, 0, 0, "refill");
        run_op(0, 1, 0, 0, 6, 0, "noop_clear");
        check_mem("noop_clear");
    endtask

    task automatic test_contention;
        run_op(1, 1, 9, 33, 2, 0, "push_and_clear");
        run_op(1, 0, 5, 44, 0, 1, "busy_push_early");
        run_op(0, 1, 0, 0, 1, 3, "busy_push_mid_clear");
        check_mem("contention");
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            int k = $urandom_range(1, 8);
            for (int p = 0; p < k; p++)
                run_op(1, 0, $urandom_range(1, 511), $urandom_range(0, 1023), 0,
                       $urandom_range(0, 3), "rand_push");
            run_op(0, 1, 0, 0, $urandom_range(0, int'(mdl_max) + 3), $urandom_range(0, 6), "rand_clear");
        end
        check_mem("random");
    endtask

    task automatic test_reset_abort;
        int k;
        run_op(1, 0, 120, 77, 0, 0, "abort_setup");
        k = $urandom_range(2, 60);
        @(negedge clk);
        start_clear = 1'b1;
        bkt_lvl_i   = 16'd0;
        @(negedge clk);
        start_clear = 1'b0;
        repeat (k) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ram_we_l_state_o !== 0 || apply_update_o !== 0 || done_update !== 0 ||
            max_lvl_o !== 0 || busy_o !== 0) begin
            failures++;
            $display("FAIL reset_abort: we=%b apply=%b done=%b max=%0d busy=%b, required all 0",
                     ram_we_l_state_o, apply_update_o, done_update, max_lvl_o, busy_o);
        end
        @(negedge clk);
        rst = 1'b1;
        mdl_max = 0;
        // Partial clear writes during the abort were not observed by either image.
        run_op(1, 0, 3, 5, 0, 0, "push_after_reset");
        check_mem("after_reset");
    endtask

    initial begin
        test_reset();
        test_push();
        test_push_sequence();
        test_clear();
        test_noop_clear();
        test_contention();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/update_global_lvl_states.md
Name: update_global_lvl_states

Overview:
Writer side of the global level-states BRAM, whose entries are {bin_id, has_bkt}. On a new global decision level it records which bin owns that level, with has_bkt=0. On a backtrack it clears every level above the backtrack level, then lowers the tracked maximum level. It sits in the bin manager next to the backtrack-level finder and shares the same BRAM port through a mux driven by apply_update_o.

Parameters:
WIDTH_LVL, 16, width of a global decision level
WIDTH_BIN_ID, 10, width of a bin id
WIDTH_LVL_STATES, 11, BRAM word width; must equal WIDTH_BIN_ID+1
ADDR_WIDTH_LVLS_STATES, 9, BRAM address width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous and active-low (rst=0 resets)
start_push  in  1  1-cycle pulse: record level lvl_i owned by bin_id_i
lvl_i  in  WIDTH_LVL  level to record
bin_id_i  in  WIDTH_BIN_ID  owning bin
start_clear  in  1  1-cycle pulse: clear levels above bkt_lvl_i
bkt_lvl_i  in  WIDTH_LVL  backtrack level
busy_o  out  1  high while not IDLE
done_update  out  1  1-cycle completion pulse
max_lvl_o  out  WIDTH_LVL  highest level currently recorded
apply_update_o  out  1  BRAM mux request; high on every cycle ram_we_l_state_o is high
ram_we_l_state_o  out  1  BRAM write enable
ram_data_l_state_o  out  WIDTH_LVL_STATES  BRAM write data {bin_id, has_bkt}
ram_addr_l_state_o  out  ADDR_WIDTH_LVLS_STATES  BRAM address

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, max_lvl_o=0, state IDLE. Asserting rst mid-operation aborts immediately; remaining writes are not issued. All outputs are registered.
- FSM states are IDLE, PUSH, CLEAR, DONE.
- Starts are sampled only in IDLE. Starts while busy are ignored (no queueing). If start_push and start_clear arrive together, clear wins and the push is dropped.
- PUSH (start_push sampled at edge E0):
  - E1: we=1, addr=lvl_i[ADDR-1:0], data={bin_id_i,1'b0}, apply=1, max_lvl_o<=lvl_i.
  - E2: we=0, apply=0, done_update=1.
  - E3: done_update=0, back to IDLE.
  - Latency is 2 cycles. lvl_i and bin_id_i are latched at E0; later input changes have no effect.
- CLEAR (start_clear sampled at E0, with N = max_lvl_o - bkt_lvl_i when max_lvl_o > bkt_lvl_i, else N = 0):
  - E1..EN: one write per cycle, we=1, data=0, apply=1. Addresses descend from max_lvl_o to bkt_lvl_i+1.
  - E(N+1): we=0, apply=0, done_update=1, max_lvl_o<=bkt_lvl_i if N>0, else unchanged.
  - E(N+2): done_update=0, IDLE.
  - N=0: no writes; done_update at E1.
  - Level 0 is never cleared. Total latency is N+1 cycles.
- Down-counter is WIDTH_LVL wide; the loop ends on a comparison to bkt_lvl_i+1, never on underflow.
- Address is the low ADDR_WIDTH_LVLS_STATES bits of the level. Upper bits are dropped (wrap), and the caller keeps levels below 2^ADDR.
- busy_o is high from E1 through the done_update cycle.
- Address and data are 0 whenever we=0.

Decomposition:
- Shared package (bin-manager constants): WIDTH_LVL, WIDTH_BIN_ID, ADDR_WIDTH_LVLS_STATES, derived WIDTH_LVL_STATES = WIDTH_BIN_ID+1, the lvl-state field order {bin_id, has_bkt}, and the FSM state encodings.
- No sub-module. The down-counter and FSM stay inline; the BRAM mux lives in the parent.

Test Plan:
- Reset: hold rst=0 mid-CLEAR at a random cycle -> we, apply, done and max_lvl_o all drop to 0 asynchronously; after release the block is in IDLE and accepts start_push.
- Push: start_push, lvl_i=3, bin_id_i=5 -> one cycle later we=1, addr=3, data={10'd5,1'b0}, apply=1; next cycle done_update=1; max_lvl_o=3.
- Push sequence: levels 1,2,3,4 with bins 7,8,9,10 -> four writes, max_lvl_o=4, BRAM model holds the matching entries.
- Clear: max_lvl_o=4, start_clear with bkt_lvl_i=1 -> writes of 0 to addresses 4,3,2 on consecutive cycles, then done_update; max_lvl_o=1; entry 1 unchanged.
- No-op clear: bkt_lvl_i=6 with max_lvl_o=4 -> no write; done_update the cycle after start; max_lvl_o stays 4.
- Contention: start_push and start_clear together -> only the clear executes. A start_push asserted while busy_o=1 -> ignored, no extra write.
